// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM-subset pipeline: operand-2 generation,
// ALU with NZCV flags, branch target resolution, and the EXE/MEM register.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] PC,
  input  logic        exe_WB_EN,
  input  logic        exe_MEM_R_EN,
  input  logic        exe_MEM_W_EN,
  input  logic [3:0]  exe_EXE_CMD,
  input  logic        exe_B,
  input  logic        exe_S,
  input  logic        exe_I,
  input  logic [31:0] exe_Val_Rn,
  input  logic [31:0] exe_Val_Rm,
  input  logic [7:0]  exe_immed_8,
  input  logic [3:0]  exe_rotate_imm,
  input  logic [1:0]  exe_shift_type,
  input  logic [4:0]  exe_shift_imm,
  input  logic [23:0] exe_Signed_imm_24,
  input  logic [3:0]  exe_Dest,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [31:0] status_reg,
  output logic        mem_WB_EN,
  output logic        mem_MEM_R_EN,
  output logic        mem_MEM_W_EN,
  output logic [31:0] mem_ALU_res,
  output logic [31:0] mem_Val_Rm,
  output logic [3:0]  mem_Dest
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  logic [3:0]  nzcv_q, nzcv_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] val_rm_q, val_rm_d;
  logic [3:0]  dest_q, dest_d;

  logic [31:0] val2;
  logic [63:0] imm_rot;
  logic [63:0] rm_ror;
  logic [31:0] op_b;
  logic        carry_in;
  logic        is_arith;
  logic [32:0] sum;
  logic [31:0] res;
  logic        flag_c;
  logic        flag_v;

  // Operand-2: memory offset beats immediate beats shifted register.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    val2    = '0;
    imm_rot = {2{24'b0, exe_immed_8}} >> {exe_rotate_imm, 1'b0};
    rm_ror  = {2{exe_Val_Rm}} >> exe_shift_imm;
    if (exe_MEM_R_EN || exe_MEM_W_EN) begin
      val2 = {20'b0, exe_rotate_imm, exe_immed_8};
    end else if (exe_I) begin
      val2 = imm_rot[31:0];
    end else begin
      unique case (shift_e'(exe_shift_type))
        SH_LSL:  val2 = exe_Val_Rm << exe_shift_imm;
        SH_LSR:  val2 = exe_Val_Rm >> exe_shift_imm;
        SH_ASR:  val2 = $signed(exe_Val_Rm) >>> exe_shift_imm;
        SH_ROR:  val2 = rm_ror[31:0];
        default: val2 = exe_Val_Rm;
      endcase
    end
  end

  // ALU: one shared 33-bit adder; subtraction feeds ~Val2 with carry-in 1 (or C).
  always_comb begin
    op_b     = val2;
    carry_in = 1'b0;
    is_arith = 1'b0;
    res      = '0;
    unique case (exe_EXE_CMD)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; carry_in = nzcv_q[1]; end
      CMD_SUB: begin is_arith = 1'b1; op_b = ~val2; carry_in = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; op_b = ~val2; carry_in = nzcv_q[1]; end
      default: ;
    endcase
    sum = {1'b0, exe_Val_Rn} + {1'b0, op_b} + {32'b0, carry_in};
    unique case (exe_EXE_CMD)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = exe_Val_Rn & val2;
      CMD_ORR: res = exe_Val_Rn | val2;
      CMD_EOR: res = exe_Val_Rn ^ val2;
      default: res = is_arith ? sum[31:0] : 32'b0;
    endcase
    // Logic/move keep the previous C and V.
    flag_c = is_arith ? sum[32] : nzcv_q[1];
    flag_v = is_arith ? ((exe_Val_Rn[31] == op_b[31]) && (res[31] != exe_Val_Rn[31]))
                      : nzcv_q[0];
  end

  // Next-state for the flags and the EXE/MEM register.
  always_comb begin
    nzcv_d     = exe_S ? {res[31], (res == 32'b0), flag_c, flag_v} : nzcv_q;
    wb_en_d    = exe_WB_EN;
    mem_r_en_d = exe_MEM_R_EN;
    mem_w_en_d = exe_MEM_W_EN;
    alu_res_d  = res;
    val_rm_d   = exe_Val_Rm;
    dest_d     = exe_Dest;
  end

  // State registers: reset wins over freeze; freeze holds everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      nzcv_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
    end else if (!freeze) begin
      nzcv_q     <= nzcv_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
    end
  end

  assign branch_taken = exe_B;
  assign branch_addr  = PC + {{6{exe_Signed_imm_24[23]}}, exe_Signed_imm_24, 2'b00};
  assign status_reg   = {nzcv_q, 28'b0};
  assign mem_WB_EN    = wb_en_q;
  assign mem_MEM_R_EN = mem_r_en_q;
  assign mem_MEM_W_EN = mem_w_en_q;
  assign mem_ALU_res  = alu_res_q;
  assign mem_Val_Rm   = val_rm_q;
  assign mem_Dest     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: each issued vector pushes its expected
// post-edge state; a monitor pops and compares one entry per clock.
module tb_exe_stage;

  typedef struct {
    logic        rst, freeze, wb, mr, mw, b, s, i;
    logic [31:0] pc, rn, rm;
    logic [3:0]  cmd, rot, dest;
    logic [7:0]  imm8;
    logic [1:0]  sht;
    logic [4:0]  shi;
    logic [23:0] imm24;
  } stim_t;

  typedef struct {
    logic        wb, mr, mw, chk_alu, chk_br, br_taken;
    logic [31:0] alu, rm, status, br_addr;
    logic [3:0]  dest;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, freeze, exe_WB_EN, exe_MEM_R_EN, exe_MEM_W_EN, exe_B, exe_S, exe_I;
  logic [31:0] PC, exe_Val_Rn, exe_Val_Rm;
  logic [3:0]  exe_EXE_CMD, exe_rotate_imm, exe_Dest;
  logic [7:0]  exe_immed_8;
  logic [1:0]  exe_shift_type;
  logic [4:0]  exe_shift_imm;
  logic [23:0] exe_Signed_imm_24;
  logic        branch_taken, mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN;
  logic [31:0] branch_addr, status_reg, mem_ALU_res, mem_Val_Rm;
  logic [3:0]  mem_Dest;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .PC(PC),
    .exe_WB_EN(exe_WB_EN), .exe_MEM_R_EN(exe_MEM_R_EN), .exe_MEM_W_EN(exe_MEM_W_EN),
    .exe_EXE_CMD(exe_EXE_CMD), .exe_B(exe_B), .exe_S(exe_S), .exe_I(exe_I),
    .exe_Val_Rn(exe_Val_Rn), .exe_Val_Rm(exe_Val_Rm), .exe_immed_8(exe_immed_8),
    .exe_rotate_imm(exe_rotate_imm), .exe_shift_type(exe_shift_type),
    .exe_shift_imm(exe_shift_imm), .exe_Signed_imm_24(exe_Signed_imm_24),
    .exe_Dest(exe_Dest), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status_reg(status_reg), .mem_WB_EN(mem_WB_EN), .mem_MEM_R_EN(mem_MEM_R_EN),
    .mem_MEM_W_EN(mem_MEM_W_EN), .mem_ALU_res(mem_ALU_res), .mem_Val_Rm(mem_Val_Rm),
    .mem_Dest(mem_Dest)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // ALU-style vector with WB enabled and no branch/memory.
  function automatic stim_t op(input logic [3:0] cmd, input logic s, input logic i,
                               input logic [31:0] rn, input logic [7:0] imm8,
                               input logic [3:0] rot, input logic [31:0] rm,
                               input logic [1:0] sht, input logic [4:0] shi,
                               input logic [3:0] dest);
    stim_t t;
    t = '{rst:0, freeze:0, wb:1, mr:0, mw:0, b:0, s:s, i:i, pc:0, rn:rn, rm:rm,
          cmd:cmd, rot:rot, dest:dest, imm8:imm8, sht:sht, shi:shi, imm24:0};
    return t;
  endfunction

  function automatic exp_t ex(input logic [31:0] alu, input logic [31:0] rm,
                              input logic [3:0] dest, input logic [31:0] status);
    exp_t e;
    e = '{wb:1, mr:0, mw:0, chk_alu:1, chk_br:1, br_taken:0,
          alu:alu, rm:rm, status:status, br_addr:0, dest:dest};
    return e;
  endfunction

  task automatic issue(input stim_t t, input exp_t e);
    @(negedge clk);
    rst = t.rst; freeze = t.freeze; PC = t.pc;
    exe_WB_EN = t.wb; exe_MEM_R_EN = t.mr; exe_MEM_W_EN = t.mw;
    exe_EXE_CMD = t.cmd; exe_B = t.b; exe_S = t.s; exe_I = t.i;
    exe_Val_Rn = t.rn; exe_Val_Rm = t.rm; exe_immed_8 = t.imm8;
    exe_rotate_imm = t.rot; exe_shift_type = t.sht; exe_shift_imm = t.shi;
    exe_Signed_imm_24 = t.imm24; exe_Dest = t.dest;
    exp_q.push_back(e);
  endtask

  // Monitor: 1 time unit after each rising edge, compare against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_ctrl", {29'b0, mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN},
              {29'b0, e.wb, e.mr, e.mw});
        check("mem_Dest", {28'b0, mem_Dest}, {28'b0, e.dest});
        check("mem_Val_Rm", mem_Val_Rm, e.rm);
        check("status_reg", status_reg, e.status);
        if (e.chk_alu) check("mem_ALU_res", mem_ALU_res, e.alu);
        if (e.chk_br) begin
          check("branch_taken", {31'b0, branch_taken}, {31'b0, e.br_taken});
          check("branch_addr", branch_addr, e.br_addr);
        end
      end
    end
  end

  initial begin
    stim_t t;
    exp_t  e;
    int    waited;

    // Reset with random inputs for two cycles (freeze may be random too).
    for (int k = 0; k < 2; k++) begin
      t = '{rst:1, freeze:1'($urandom), wb:1'($urandom), mr:1'($urandom), mw:1'($urandom),
            b:1'($urandom), s:1'($urandom), i:1'($urandom), pc:$urandom, rn:$urandom,
            rm:$urandom, cmd:4'($urandom), rot:4'($urandom), dest:4'($urandom),
            imm8:8'($urandom), sht:2'($urandom), shi:5'($urandom), imm24:24'($urandom)};
      e = ex(32'h0, 32'h0, 4'h0, 32'h0);
      e.wb = 0; e.chk_br = 0;
      issue(t, e);
    end

    // ADD S: 0x7FFFFFFF + 1 -> N,V set.
    issue(op(4'b0010, 1, 1, 32'h7FFF_FFFF, 8'h01, 4'h0, 32'h0000_1234, 2'b00, 5'd0, 4'd3),
          ex(32'h8000_0000, 32'h0000_1234, 4'd3, 32'h9000_0000));
    // SUB S: 5 - 5 -> Z,C set.
    issue(op(4'b0100, 1, 1, 32'd5, 8'h05, 4'h0, 32'h0, 2'b00, 5'd0, 4'd4),
          ex(32'h0, 32'h0, 4'd4, 32'h6000_0000));
    // ADC with C=1: 1 + 1 + 1.
    issue(op(4'b0011, 0, 1, 32'd1, 8'h01, 4'h0, 32'h0, 2'b00, 5'd0, 4'd1),
          ex(32'd3, 32'h0, 4'd1, 32'h6000_0000));
    // MOV S of rotated immediate 0xFF ror 8; C,V kept.
    issue(op(4'b0001, 1, 1, 32'h0, 8'hFF, 4'h4, 32'h0, 2'b00, 5'd0, 4'd2),
          ex(32'hFF00_0000, 32'h0, 4'd2, 32'hA000_0000));
    // MOV of register ASR 4.
    issue(op(4'b0001, 0, 0, 32'h0, 8'h00, 4'h0, 32'h8000_0000, 2'b10, 5'd4, 4'd6),
          ex(32'hF800_0000, 32'h8000_0000, 4'd6, 32'hA000_0000));
    // Backward branch, bubble in the pipe.
    t = op(4'b0000, 0, 0, 32'h0, 8'h00, 4'h0, 32'h0, 2'b00, 5'd0, 4'd0);
    t.wb = 0; t.b = 1; t.pc = 32'h100; t.imm24 = 24'hFFFFFE;
    e = ex(32'h0, 32'h0, 4'd0, 32'hA000_0000);
    e.wb = 0; e.chk_alu = 0; e.br_taken = 1; e.br_addr = 32'h0000_00F8;
    issue(t, e);
    // ORR to give freeze a known value to hold.
    issue(op(4'b0111, 0, 1, 32'h0000_00F0, 8'h0F, 4'h0, 32'h0000_0077, 2'b00, 5'd0, 4'd5),
          ex(32'h0000_00FF, 32'h0000_0077, 4'd5, 32'hA000_0000));
    // Frozen ADD S for two cycles: everything holds.
    t = op(4'b0010, 1, 1, 32'h7FFF_FFFF, 8'h01, 4'h0, 32'h0000_0099, 2'b00, 5'd0, 4'd9);
    t.freeze = 1;
    issue(t, ex(32'h0000_00FF, 32'h0000_0077, 4'd5, 32'hA000_0000));
    issue(t, ex(32'h0000_00FF, 32'h0000_0077, 4'd5, 32'hA000_0000));
    // Release: the same ADD lands.
    t.freeze = 0;
    issue(t, ex(32'h8000_0000, 32'h0000_0099, 4'd9, 32'h9000_0000));
    // STR: 12-bit offset beats the shifted-register operand.
    t = op(4'b0010, 0, 0, 32'h0000_0200, 8'h0C, 4'h0, 32'hDEAD_BEEF, 2'b00, 5'd1, 4'd2);
    t.wb = 0; t.mw = 1;
    e = ex(32'h0000_020C, 32'hDEAD_BEEF, 4'd2, 32'h9000_0000);
    e.wb = 0; e.mw = 1;
    issue(t, e);
    // LDR: offset {rot,imm8} = 0x123, not a rotated immediate.
    t = op(4'b0010, 0, 1, 32'h0000_1000, 8'h23, 4'h1, 32'h0000_0055, 2'b00, 5'd0, 4'd7);
    t.mr = 1;
    e = ex(32'h0000_1123, 32'h0000_0055, 4'd7, 32'h9000_0000);
    e.mr = 1;
    issue(t, e);
    // SBC S with C=0: 10 - 3 - 1 = 6, no borrow -> C=1.
    issue(op(4'b0101, 1, 1, 32'd10, 8'h03, 4'h0, 32'h0, 2'b00, 5'd0, 4'd8),
          ex(32'd6, 32'h0, 4'd8, 32'h2000_0000));
    // EOR S with register ROR 4.
    issue(op(4'b1000, 1, 0, 32'hFFFF_0000, 8'h00, 4'h0, 32'h0000_00F1, 2'b11, 5'd4, 4'd10),
          ex(32'hEFFF_000F, 32'h0000_00F1, 4'd10, 32'hA000_0000));
    // MVN of register LSR 28.
    issue(op(4'b1001, 0, 0, 32'h0, 8'h00, 4'h0, 32'hF000_0000, 2'b01, 5'd28, 4'd11),
          ex(32'hFFFF_FFF0, 32'hF000_0000, 4'd11, 32'hA000_0000));
    // ASR by 0 leaves Val_Rm unchanged.
    issue(op(4'b0001, 0, 0, 32'h0, 8'h00, 4'h0, 32'h8000_0001, 2'b10, 5'd0, 4'd12),
          ex(32'h8000_0001, 32'h8000_0001, 4'd12, 32'hA000_0000));
    // Undefined command yields 0.
    issue(op(4'b1111, 0, 1, 32'd5, 8'h05, 4'h0, 32'h0, 2'b00, 5'd0, 4'd13),
          ex(32'h0, 32'h0, 4'd13, 32'hA000_0000));
    // Forward branch while an ADD also registers.
    t = op(4'b0010, 0, 1, 32'd1, 8'h01, 4'h0, 32'h0, 2'b00, 5'd0, 4'd14);
    t.b = 1; t.pc = 32'h0000_1000; t.imm24 = 24'h000010;
    e = ex(32'd2, 32'h0, 4'd14, 32'hA000_0000);
    e.br_taken = 1; e.br_addr = 32'h0000_1040;
    issue(t, e);
    // Reset has priority over freeze.
    t = op(4'b0010, 1, 1, 32'd1, 8'h01, 4'h0, 32'h1, 2'b00, 5'd0, 4'd15);
    t.rst = 1; t.freeze = 1;
    e = ex(32'h0, 32'h0, 4'd0, 32'h0);
    e.wb = 0;
    issue(t, e);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
